// File: rtl/ram_dump_uart_pkg.sv
// Shared types and constants for the post-halt RAM dump over UART.
// The optional checksum frame is enabled by defining RAM_DUMP_CHECKSUM_EN.
package ram_dump_uart_pkg;

    // Dump sequencer states; CSUM is only reachable when the checksum frame is built in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6
    } ram_dump_state_e;

    // Line level between frames and during the stop bit.
    localparam logic UartIdleLevel = 1'b1;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned UartFrameBits = 10;

    // Running modulo-256 sum of the bytes sent.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/ram_dump_uart_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each ClksPerBit clocks.
// busy drops one clock before the end of the stop bit so that a caller watching
// for its falling edge leaves its send phase exactly when the frame ends.
module ram_dump_uart_uart_tx
    import ram_dump_uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BaudW = $clog2(ClksPerBit);
    localparam logic [BaudW-1:0] BaudLast   = BaudW'(ClksPerBit - 1);
    localparam logic [BaudW-1:0] BaudPenult = BaudW'(ClksPerBit - 2);
    localparam logic [3:0]       StopIdx    = 4'(UartFrameBits - 1);

    logic [BaudW-1:0] r_baud_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_frame;
    logic             r_tx;
    logic             r_busy;

    // Baud timing, bit sequencing and the registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_frame    <= 9'h1FF;
            r_tx       <= UartIdleLevel;
            r_busy     <= 1'b0;
        end else if (!r_busy && start) begin
            // Start bit goes out immediately; remaining bits are data then stop.
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_frame    <= {1'b1, data};
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
        end else if (r_busy) begin
            if (r_baud_cnt == BaudLast) begin
                r_baud_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_tx       <= r_frame[0];
                r_frame    <= {1'b1, r_frame[8:1]};
            end else begin
                r_baud_cnt <= r_baud_cnt + {{(BaudW-1){1'b0}}, 1'b1};
            end
            // Release busy for the final clock of the stop bit; the line stays high.
            if ((r_bit_cnt == StopIdx) && (r_baud_cnt == BaudPenult)) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else begin
            r_tx <= UartIdleLevel;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: rtl/ram_dump_uart.sv
// Post-halt data RAM dump: walks every word through the debug port and sends each
// byte (little-endian, word 0 first) as an 8N1 UART frame.
// Define RAM_DUMP_CHECKSUM_EN to append one frame carrying the modulo-256 byte sum.
module ram_dump_uart
    import ram_dump_uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = 868,
    parameter int unsigned NWords     = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       halt,
    output logic       ram_debug_en,
    output logic [7:0] ram_addr,
    output logic [1:0] ram_byte_sel,
    input  logic [7:0] ram_data,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    // 9-bit word index so NWords=256 terminates without wrapping.
    localparam logic [8:0] LastWord = 9'(NWords - 1);
`ifdef RAM_DUMP_CHECKSUM_EN
    localparam logic [8:0] AllWords = 9'(NWords);
`endif

    ram_dump_state_e r_state;
    ram_dump_state_e w_state_nxt;
    logic [8:0]      r_word_idx;
    logic [8:0]      w_word_idx_nxt;
    logic [1:0]      r_byte_idx;
    logic [1:0]      w_byte_idx_nxt;
    logic            w_tx_start;
    logic [7:0]      w_tx_data;
    logic            w_tx_busy;
    logic            w_tx;
`ifdef RAM_DUMP_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    ram_dump_uart_uart_tx #(
        .ClksPerBit (ClksPerBit)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (w_tx_start),
        .data  (w_tx_data),
        .tx    (w_tx),
        .busy  (w_tx_busy)
    );

    // State and index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_word_idx <= 9'd0;
            r_byte_idx <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

`ifdef RAM_DUMP_CHECKSUM_EN
    // Accumulate every captured data byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if (r_state == ST_CAPTURE) begin
            r_csum <= csum_add(r_csum, ram_data);
        end else begin
            r_csum <= r_csum;
        end
    end
`endif

    // Next-state, index advance and UART frame launch.
    // The frame is launched while leaving CAPTURE so the start bit begins on the
    // first clock of SEND, which then lasts exactly one frame.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_start     = 1'b0;
        w_tx_data      = ram_data;
        case (r_state)
            ST_IDLE: begin
                if (halt) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_tx_start  = 1'b1;
                w_tx_data   = ram_data;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_tx_busy) begin
                    w_state_nxt = ST_SEND;
`ifdef RAM_DUMP_CHECKSUM_EN
                end else if (r_word_idx == AllWords) begin
                    // Checksum frame finished.
                    w_state_nxt = ST_DONE;
`endif
                end else if (r_byte_idx != 2'd3) begin
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    w_state_nxt    = ST_FETCH;
                end else begin
                    w_byte_idx_nxt = 2'd0;
                    w_word_idx_nxt = r_word_idx + 9'd1;
                    if (r_word_idx == LastWord) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                        w_state_nxt = ST_CSUM;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_CSUM: begin
`ifdef RAM_DUMP_CHECKSUM_EN
                w_tx_start  = 1'b1;
                w_tx_data   = r_csum;
                w_state_nxt = ST_SEND;
`else
                w_state_nxt = ST_DONE;
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered port outputs derived from the upcoming state, so they change
    // on the same edge as the state and stay glitch-free between bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_debug_en <= 1'b0;
            ram_addr     <= 8'd0;
            ram_byte_sel <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ram_debug_en <= (w_state_nxt != ST_IDLE);
            ram_addr     <= w_word_idx_nxt[7:0];
            ram_byte_sel <= w_byte_idx_nxt;
            busy         <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            done         <= (w_state_nxt == ST_DONE);
        end
    end

    assign uart_tx = w_tx;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: registered-read RAM model, UART receiver feeding a
// byte scoreboard, plus reset/idle/timing checks. Define RAM_DUMP_CHECKSUM_EN to
// expect the trailing checksum frame.
module tb_ram_dump_uart;

    localparam int CPB = 4;
    localparam logic [31:0] W0 = 32'h11223344;
    localparam logic [31:0] W1 = 32'hA5A5005A;
`ifdef RAM_DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
    localparam int N_FRAMES = 9;
`else
    localparam bit CSUM_ON = 1'b0;
    localparam int N_FRAMES = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       halt = 1'b0;
    logic       ram_debug_en;
    logic [7:0] ram_addr;
    logic [1:0] ram_byte_sel;
    logic [7:0] ram_data;
    logic       uart_tx;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    bit         rx_flush = 1'b0;
    int         rx_nframes = 0;
    int         last_start = 0;
    int         halt_drop_at = -1;

    logic [31:0] r_rd_word = 32'h0;

    ram_dump_uart #(
        .ClksPerBit (CPB),
        .NWords     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .halt         (halt),
        .ram_debug_en (ram_debug_en),
        .ram_addr     (ram_addr),
        .ram_byte_sel (ram_byte_sel),
        .ram_data     (ram_data),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered word read, combinational byte select.
    always @(posedge clk)
        r_rd_word <= (ram_addr == 8'd0) ? W0 : ((ram_addr == 8'd1) ? W1 : 32'hDEADBEEF);
    assign ram_data = r_rd_word[8*ram_byte_sel +: 8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_expected();
        logic [31:0] w;
        logic [7:0]  sum;
        sum = 8'd0;
        for (int wi = 0; wi < 2; wi++) begin
            w = (wi == 0) ? W0 : W1;
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
            end
        end
        if (CSUM_ON) exp_q.push_back(sum);
    endtask

    // UART receiver: samples 1 time unit after each rising edge.
    initial begin : rx
        int         rx_cnt;
        int         rx_low;
        bit         rx_stop;
        logic [7:0] rx_byte;
        rx_cnt  = -1;
        rx_low  = 0;
        rx_stop = 1'b1;
        rx_byte = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (rx_flush) begin
                rx_cnt     = -1;
                rx_nframes = 0;
            end else if (rx_cnt < 0) begin
                if (uart_tx === 1'b0) begin
                    if (rx_nframes > 0)
                        chk("frame_gap", 32'(cyc - last_start),
                            (CSUM_ON && rx_nframes == 8) ? 32'd41 : 32'd43);
                    last_start = cyc;
                    rx_low  = 1;
                    rx_stop = 1'b1;
                    rx_byte = 8'd0;
                    rx_cnt  = 1;
                end
            end else begin
                if (rx_cnt < 4 && uart_tx === 1'b0) rx_low++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                    rx_byte[(rx_cnt - 6) / 4] = uart_tx;
                if (rx_cnt >= 36 && uart_tx !== 1'b1) rx_stop = 1'b0;
                if (rx_cnt == 39) begin
                    chk("start_bit_len", rx_low, 32'd4);
                    chk("stop_bit", {31'd0, rx_stop}, 32'd1);
                    if (exp_q.size() == 0)
                        chk("extra_frame", {24'd0, rx_byte}, 32'h100);
                    else
                        chk("frame_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                    rx_nframes++;
                    rx_cnt = -1;
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        halt     = 1'b0;
        reset    = 1'b1;
        rx_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rx_flush = 1'b0;
    endtask

    // Runs until done (bounded), checking debug-enable continuity and done/busy timing.
    task automatic run_dump(input string name);
        bit   seen_en;
        bit   got_done;
        logic prev_busy;
        int   en_glitch;
        seen_en   = 1'b0;
        got_done  = 1'b0;
        prev_busy = 1'b0;
        en_glitch = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (halt_drop_at >= 0 && rx_nframes == halt_drop_at) halt = 1'b0;
            if (seen_en && ram_debug_en !== 1'b1) en_glitch++;
            if (ram_debug_en === 1'b1) seen_en = 1'b1;
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            prev_busy = busy;
        end
        chk({name, "_done_seen"}, {31'd0, got_done}, 32'd1);
        chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_busy_before_done"}, {31'd0, prev_busy}, 32'd1);
        chk({name, "_done_after_stop"}, 32'(cyc - last_start), 32'd40);
        chk({name, "_en_continuous"}, en_glitch, 32'd0);
        chk({name, "_frames"}, rx_nframes, N_FRAMES);
        chk({name, "_queue_left"}, exp_q.size(), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk({name, "_done_sticky"}, {31'd0, done}, 32'd1);
        chk({name, "_en_in_done"}, {31'd0, ram_debug_en}, 32'd1);
        chk({name, "_tx_in_done"}, {31'd0, uart_tx}, 32'd1);
        chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : main
        int bad_en;
        int bad_tx;
        int bad_busy;
        rx_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_debug_en", {31'd0, ram_debug_en}, 32'd0);
        chk("rst_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_byte_sel", {30'd0, ram_byte_sel}, 32'd0);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        rx_flush = 1'b0;

        // Idle with halt low.
        bad_en = 0; bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ram_debug_en !== 1'b0) bad_en++;
            if (uart_tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("idle_debug_en", bad_en, 32'd0);
        chk("idle_tx", bad_tx, 32'd0);
        chk("idle_busy", bad_busy, 32'd0);

        // Full dump.
        push_expected();
        halt = 1'b1;
        run_dump("full");

        // Reset during the third frame's start bit, halt kept high.
        do_reset();
        push_expected();
        halt = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rx_nframes == 2 && uart_tx === 1'b0) break;
        end
        chk("mid_reset_in_frame3", {31'd0, uart_tx}, 32'd0);
        reset    = 1'b1;
        rx_flush = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid_reset_debug_en", {31'd0, ram_debug_en}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        push_expected();
        @(posedge clk); #1;
        rx_flush = 1'b0;
        run_dump("restart");

        // halt dropped during word 1.
        do_reset();
        push_expected();
        halt_drop_at = 5;
        halt = 1'b1;
        run_dump("halt_drop");
        halt_drop_at = -1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
